debounce_scheduler: RTL and testbench

DEBOUNCE_SCHEDULER -- requirements
Module: debounce_scheduler

---
 rtl/debounce_scheduler.sv | 228 ++++++++++++++++++++++
 tb/tb_debounce_scheduler.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/debounce_scheduler.sv
// -----------------------------------------------------------------------------
// debounce_scheduler
//
// Debounces NUM_SW switch inputs with one shared timer. A round-robin scheduler
// grants one pending switch at a time. The switch must hold its new level for
// DELAY_CNT+1 COUNT cycles. When it does, the debounced output bit updates and
// a valid/ready event reports the switch index and its new level.
//
// Ports:
//   clk        clock; all state updates on the rising edge
//   rst_n      asynchronous active-low reset
//   sw         raw asynchronous switch levels (NUM_SW bits)
//   out        debounced switch levels, registered (NUM_SW bits)
//   evt_valid  debounced-change event available
//   evt_ready  consumer accepts the event (ignored while evt_valid is low)
//   evt_id     index of the switch that changed
//   evt_level  new debounced level of evt_id
//   busy       high while the scheduler is not IDLE
// -----------------------------------------------------------------------------
module debounce_scheduler #(
    parameter int NUM_SW    = 4,
    parameter int DELAY_CNT = 3,
    parameter int CNT_W     = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_SW-1:0]         sw,
    output logic [NUM_SW-1:0]         out,
    output logic                      evt_valid,
    input  logic                      evt_ready,
    output logic [$clog2(NUM_SW)-1:0] evt_id,
    output logic                      evt_level,
    output logic                      busy
);

    localparam int ID_W = $clog2(NUM_SW);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_EMIT  = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_nxt_s;

    logic [NUM_SW-1:0]   sync1_r;
    logic [NUM_SW-1:0]   sw_s;
    logic [NUM_SW-1:0]   pending_s;

    logic [ID_W-1:0]     rr_ptr_r;
    logic [ID_W-1:0]     grant_r;
    logic                cand_r;
    logic [CNT_W-1:0]    timer_r;

    logic [NUM_SW-1:0]   out_r;
    logic                evt_valid_r;
    logic [ID_W-1:0]     evt_id_r;
    logic                evt_level_r;
    logic                busy_r;

    logic                grant_found_s;
    logic [ID_W-1:0]     grant_idx_s;
    logic [ID_W-1:0]     next_ptr_s;
    logic [ID_W:0]       scan_idx_s;

    logic                do_grant_s;
    logic                do_dec_s;
    logic                do_emit_s;
    logic                do_ack_s;

    assign out       = out_r;
    assign evt_valid = evt_valid_r;
    assign evt_id    = evt_id_r;
    assign evt_level = evt_level_r;
    assign busy      = busy_r;

    // A switch needs attention whenever its synchronized level differs from
    // its debounced level; returning to the old level clears it silently.
    assign pending_s = sw_s ^ out_r;

    // Two-flop synchronizer; only sw_s is used downstream of the raw inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= '0;
            sw_s    <= '0;
        end else begin
            sync1_r <= sw;
            sw_s    <= sync1_r;
        end
    end

    // Round-robin search: first pending index at or after rr_ptr, wrapping.
    // The scan index is one bit wider so rr_ptr + k cannot overflow before
    // the modulo correction.
    always_comb begin
        grant_found_s = 1'b0;
        grant_idx_s   = '0;
        scan_idx_s    = '0;
        for (int k = 0; k < NUM_SW; k++) begin
            scan_idx_s = {1'b0, rr_ptr_r} + (ID_W+1)'(k);
            if (scan_idx_s >= (ID_W+1)'(NUM_SW)) begin
                scan_idx_s = scan_idx_s - (ID_W+1)'(NUM_SW);
            end else begin
                scan_idx_s = scan_idx_s;
            end
            if (!grant_found_s && pending_s[scan_idx_s[ID_W-1:0]]) begin
                grant_found_s = 1'b1;
                grant_idx_s   = scan_idx_s[ID_W-1:0];
            end else begin
                grant_found_s = grant_found_s;
                grant_idx_s   = grant_idx_s;
            end
        end
    end

    // Pointer value that follows the granted index, modulo NUM_SW.
    always_comb begin
        next_ptr_s = '0;
        if (grant_idx_s == ID_W'(NUM_SW - 1)) begin
            next_ptr_s = '0;
        end else begin
            next_ptr_s = grant_idx_s + ID_W'(1);
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state and datapath control strobes.
    always_comb begin
        state_nxt_s = state_r;
        do_grant_s  = 1'b0;
        do_dec_s    = 1'b0;
        do_emit_s   = 1'b0;
        do_ack_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (grant_found_s) begin
                    do_grant_s  = 1'b1;
                    state_nxt_s = ST_COUNT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_COUNT: begin
                // A bounce on the granted switch abandons the candidate; the
                // switch simply becomes pending again if it still differs.
                if (sw_s[grant_r] != cand_r) begin
                    state_nxt_s = ST_IDLE;
                end else if (timer_r != '0) begin
                    do_dec_s    = 1'b1;
                    state_nxt_s = ST_COUNT;
                end else begin
                    do_emit_s   = 1'b1;
                    state_nxt_s = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (evt_ready) begin
                    do_ack_s    = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_EMIT;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Grant bookkeeping and shared debounce timer. An abort leaves the timer
    // as it was; every grant reloads it anyway.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_r <= '0;
            grant_r  <= '0;
            cand_r   <= 1'b0;
            timer_r  <= CNT_W'(DELAY_CNT);
        end else if (do_grant_s) begin
            rr_ptr_r <= next_ptr_s;
            grant_r  <= grant_idx_s;
            cand_r   <= sw_s[grant_idx_s];
            timer_r  <= CNT_W'(DELAY_CNT);
        end else if (do_dec_s) begin
            timer_r  <= timer_r - CNT_W'(1);
        end else begin
            timer_r  <= timer_r;
        end
    end

    // Debounced outputs and event register: the out bit and the event are
    // written on the same edge so an event always matches a real change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_r       <= '0;
            evt_valid_r <= 1'b0;
            evt_id_r    <= '0;
            evt_level_r <= 1'b0;
        end else if (do_emit_s) begin
            out_r[grant_r] <= cand_r;
            evt_valid_r    <= 1'b1;
            evt_id_r       <= grant_r;
            evt_level_r    <= cand_r;
        end else if (do_ack_s) begin
            evt_valid_r <= 1'b0;
        end else begin
            evt_valid_r <= evt_valid_r;
        end
    end

    // Busy flag registered from the next state so it tracks "not IDLE".
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r <= 1'b0;
        end else begin
            busy_r <= (state_nxt_s != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_debounce_scheduler.sv
module tb_debounce_scheduler;

    localparam int NUM_SW    = 4;
    localparam int DELAY_CNT = 3;

    logic       clk;
    logic       rst_n;
    logic [3:0] sw;
    logic [3:0] out;
    logic       evt_valid;
    logic       evt_ready;
    logic [1:0] evt_id;
    logic       evt_level;
    logic       busy;

    int total = 0;
    int bad   = 0;
    int evt_count = 0;

    debounce_scheduler #(
        .NUM_SW   (4),
        .DELAY_CNT(3),
        .CNT_W    (2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sw       (sw),
        .out      (out),
        .evt_valid(evt_valid),
        .evt_ready(evt_ready),
        .evt_id   (evt_id),
        .evt_level(evt_level),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count completed handshakes.
    always @(posedge clk) begin
        if (rst_n && evt_valid && evt_ready) evt_count <= evt_count + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_busy(input int budget, output bit ok, output int n);
        ok = 1'b0;
        n  = 0;
        while (n < budget && !ok) begin
            tick();
            n++;
            if (busy === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic wait_evt(input int budget, output bit ok, output int n);
        ok = 1'b0;
        n  = 0;
        while (n < budget && !ok) begin
            tick();
            n++;
            if (evt_valid === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; sw = 4'b0000; evt_ready = 1'b1;
        tick(); tick(); tick();
        total++; if (out !== 4'b0000) begin bad++; $display("FAIL reset_out: got %b expected 0000", out); end
        total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b expected 0", evt_valid); end
        total++; if (evt_id !== 2'd0) begin bad++; $display("FAIL reset_id: got %0d expected 0", evt_id); end
        total++; if (evt_level !== 1'b0) begin bad++; $display("FAIL reset_level: got %b expected 0", evt_level); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
        rst_n = 1'b1;
        tick(); tick();
    endtask

    task automatic test_single();
        bit ok; int n;
        sw = 4'b0001;
        wait_busy(10, ok, n);
        total++; if (!ok || out !== 4'b0000) begin bad++; $display("FAIL single_grant: busy=%b out=%b expected busy=1 out=0000", busy, out); end
        wait_evt(10, ok, n);
        total++; if (!ok || n != DELAY_CNT + 1) begin bad++; $display("FAIL single_latency: got %0d edges after grant expected %0d", n, DELAY_CNT + 1); end
        total++; if (evt_id !== 2'd0 || evt_level !== 1'b1) begin bad++; $display("FAIL single_evt: got id=%0d lvl=%b expected id=0 lvl=1", evt_id, evt_level); end
        total++; if (out !== 4'b0001) begin bad++; $display("FAIL single_out: got %b expected 0001", out); end
        tick();
        total++; if (evt_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL single_ack: got valid=%b busy=%b expected 0 0", evt_valid, busy); end
        tick(); tick(); tick();
        total++; if (evt_count != 1 || busy !== 1'b0) begin bad++; $display("FAIL single_count: got events=%0d busy=%b expected 1 0", evt_count, busy); end
    endtask

    task automatic test_abort();
        bit ok; int n; int base; bit saw_busy;
        base = evt_count;
        saw_busy = 1'b0;
        sw = 4'b0101;
        tick(); tick();
        sw = 4'b0001;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (busy === 1'b1) saw_busy = 1'b1;
        end
        total++; if (saw_busy !== 1'b1) begin bad++; $display("FAIL abort_granted: got busy_seen=%b expected 1", saw_busy); end
        total++; if (out !== 4'b0001 || evt_count != base || busy !== 1'b0) begin bad++; $display("FAIL abort_noevt: got out=%b events=%0d busy=%b expected 0001 %0d 0", out, evt_count, busy, base); end
        sw = 4'b0101;
        wait_evt(20, ok, n);
        total++; if (!ok || evt_id !== 2'd2 || evt_level !== 1'b1 || out !== 4'b0101) begin bad++; $display("FAIL abort_retry: got ok=%b id=%0d lvl=%b out=%b expected 1 2 1 0101", ok, evt_id, evt_level, out); end
        tick();
        total++; if (evt_count != base + 1) begin bad++; $display("FAIL abort_count: got %0d expected %0d", evt_count, base + 1); end
    endtask

    task automatic test_all_at_once();
        bit ok; int n;
        logic [3:0] exp_out;
        rst_n = 1'b0; sw = 4'b0000;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        sw = 4'b1111;
        exp_out = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            exp_out[k] = 1'b1;
            wait_evt(20, ok, n);
            total++; if (!ok || evt_id !== 2'(k) || evt_level !== 1'b1 || out !== exp_out) begin bad++; $display("FAIL all_evt%0d: got ok=%b id=%0d lvl=%b out=%b expected id=%0d lvl=1 out=%b", k, ok, evt_id, evt_level, out, k, exp_out); end
            tick();
        end
    endtask

    task automatic test_backpressure();
        bit ok; int n; int base;
        evt_ready = 1'b0;
        sw = 4'b1110;
        wait_evt(20, ok, n);
        total++; if (!ok || evt_id !== 2'd0 || evt_level !== 1'b0 || out !== 4'b1110) begin bad++; $display("FAIL bp_evt: got ok=%b id=%0d lvl=%b out=%b expected 1 0 0 1110", ok, evt_id, evt_level, out); end
        for (int i = 0; i < 10; i++) begin
            if (i == 0) sw = 4'b1000;
            if (i == 3) sw = 4'b1100;
            tick();
            total++; if (evt_valid !== 1'b1 || evt_id !== 2'd0 || evt_level !== 1'b0 || out !== 4'b1110 || busy !== 1'b1) begin bad++; $display("FAIL bp_hold%0d: got v=%b id=%0d lvl=%b out=%b busy=%b expected 1 0 0 1110 1", i, evt_valid, evt_id, evt_level, out, busy); end
        end
        base = evt_count;
        evt_ready = 1'b1;
        tick();
        total++; if (evt_valid !== 1'b0 || evt_count != base + 1) begin bad++; $display("FAIL bp_ack: got valid=%b events=%0d expected 0 %0d", evt_valid, evt_count, base + 1); end
        wait_evt(20, ok, n);
        total++; if (!ok || n != DELAY_CNT + 2) begin bad++; $display("FAIL bp_next_latency: got %0d expected %0d", n, DELAY_CNT + 2); end
        total++; if (evt_id !== 2'd1 || evt_level !== 1'b0 || out !== 4'b1100) begin bad++; $display("FAIL bp_next_evt: got id=%0d lvl=%b out=%b expected 1 0 1100", evt_id, evt_level, out); end
        tick();
        base = evt_count;
        for (int i = 0; i < 12; i++) tick();
        total++; if (evt_count != base || out !== 4'b1100) begin bad++; $display("FAIL bp_glitch_quiet: got events=%0d out=%b expected %0d 1100", evt_count, out, base); end
    endtask

    task automatic test_reset_mid_count();
        bit ok; int n; int base;
        rst_n = 1'b0; sw = 4'b0000;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        base = evt_count;
        sw = 4'b0100;
        wait_busy(10, ok, n);
        tick();
        rst_n = 1'b0;
        #1;
        total++; if (!ok || out !== 4'b0000 || evt_valid !== 1'b0 || evt_id !== 2'd0 || evt_level !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rstmid_outs: got ok=%b out=%b v=%b id=%0d lvl=%b busy=%b expected all 0", ok, out, evt_valid, evt_id, evt_level, busy); end
        tick(); tick();
        rst_n = 1'b1;
        wait_evt(20, ok, n);
        total++; if (!ok || n != DELAY_CNT + 4) begin bad++; $display("FAIL rstmid_latency: got %0d expected %0d", n, DELAY_CNT + 4); end
        total++; if (evt_id !== 2'd2 || evt_level !== 1'b1 || out !== 4'b0100 || evt_count != base) begin bad++; $display("FAIL rstmid_evt: got id=%0d lvl=%b out=%b events=%0d expected 2 1 0100 %0d", evt_id, evt_level, out, evt_count, base); end
        tick();
        total++; if (evt_count != base + 1) begin bad++; $display("FAIL rstmid_count: got %0d expected %0d", evt_count, base + 1); end
    endtask

    task automatic test_wrap();
        bit ok; int n;
        sw = 4'b1100;
        wait_evt(20, ok, n);
        total++; if (!ok || evt_id !== 2'd3 || evt_level !== 1'b1 || out !== 4'b1100) begin bad++; $display("FAIL wrap_first: got id=%0d lvl=%b out=%b expected 3 1 1100", evt_id, evt_level, out); end
        tick();
        sw = 4'b0101;
        wait_evt(20, ok, n);
        total++; if (!ok || evt_id !== 2'd0 || evt_level !== 1'b1 || out !== 4'b1101) begin bad++; $display("FAIL wrap_second: got id=%0d lvl=%b out=%b expected 0 1 1101", evt_id, evt_level, out); end
        tick();
        wait_evt(20, ok, n);
        total++; if (!ok || evt_id !== 2'd3 || evt_level !== 1'b0 || out !== 4'b0101) begin bad++; $display("FAIL wrap_third: got id=%0d lvl=%b out=%b expected 3 0 0101", evt_id, evt_level, out); end
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        sw = 4'b0000;
        evt_ready = 1'b1;
        test_reset();
        test_single();
        test_abort();
        test_all_at_once();
        test_backpressure();
        test_reset_mid_count();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
